// File: rtl/booth_cu.sv
`default_nettype none
// ============================================================================
// Module   : booth_cu
// Purpose  : Moore control unit for a radix-2 Booth 8x8 signed multiplier.
//            Optional debug taps are enabled by defining BOOTH_CU_DBG_EN.
// Revision : 1.0
// ============================================================================
module booth_cu (
    input  logic       clk,
    input  logic       rst,
    input  logic       bgn,
    input  logic       q0,
    input  logic       q_m1,
    output logic       c0,
    output logic       c1,
    output logic       c2,
    output logic       c3,
    output logic       c4,
    output logic       c6,
    output logic       c7,
    output logic       fin
`ifdef BOOTH_CU_DBG_EN
    ,
    output logic [3:0] dbg_state,
    output logic [2:0] dbg_cnt
`endif
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LOAD_M = 4'd1,
        LOAD_Q = 4'd2,
        TEST   = 4'd3,
        ADD    = 4'd4,
        SUB    = 4'd5,
        SHIFT  = 4'd6,
        OUT_A  = 4'd7,
        OUT_Q  = 4'd8,
        DONE   = 4'd9
    } state_t;

    localparam logic [2:0] C_LAST_ITER = 3'd7;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:   state_d = bgn ? LOAD_M : IDLE;
            LOAD_M: begin
                state_d = LOAD_Q;
                cnt_d   = 3'd0;
            end
            LOAD_Q: state_d = TEST;
            TEST: begin
                case ({q0, q_m1})
                    2'b01:   state_d = ADD;
                    2'b10:   state_d = SUB;
                    default: state_d = SHIFT;
                endcase
            end
            ADD:    state_d = SHIFT;
            SUB:    state_d = SHIFT;
            SHIFT: begin
                // Counter wraps to 0 on the last shift; LOAD_M reinitialises it anyway.
                cnt_d   = cnt_q + 3'd1;
                state_d = (cnt_q == C_LAST_ITER) ? OUT_A : TEST;
            end
            OUT_A:  state_d = OUT_Q;
            OUT_Q:  state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode from the state register only, so they are glitch-free per cycle.
    assign c0  = (state_q == LOAD_M);
    assign c1  = (state_q == LOAD_Q);
    assign c2  = (state_q == ADD);
    assign c3  = (state_q == SUB);
    assign c4  = (state_q == SHIFT);
    assign c6  = (state_q == OUT_A);
    assign c7  = (state_q == OUT_Q);
    assign fin = (state_q == DONE);

`ifdef BOOTH_CU_DBG_EN
    assign dbg_state = state_q;
    assign dbg_cnt   = cnt_q;
`endif

endmodule
`default_nettype wire
